jk_bank_sequencer: RTL

- Command-driven controller for a bank of WIDTH single-bit JK flip-flops; the bank sits beside it on the same clock.
- Each cycle it drives the bank's per-bit J/K inputs and reads back the bank's Q outputs.
- It turns bank operations (load, clear, multi-step up/down count, masked toggle) into J/K sequences, with a valid/ready command handshake and a done pulse.
- The bank has no reset, so this block also brings the bank to a known zero state after reset.

---
 rtl/jk_bank_sequencer_if.sv | 28 ++
 rtl/jk_bank_sequencer.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/jk_bank_sequencer_if.sv
// Command handshake and JK-bank connection bundle for jk_bank_sequencer.
// The master side issues commands and owns the bank; the slave side is the sequencer.
interface jk_bank_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             iCmdValid;
    logic             oCmdReady;
    logic [2:0]       iCmdOp;
    logic [WIDTH-1:0] iCmdData;
    logic [CNT_W-1:0] iCmdCount;
    logic             iAbort;
    logic [WIDTH-1:0] iQ;
    logic [WIDTH-1:0] oJ;
    logic [WIDTH-1:0] oK;
    logic             oBusy;
    logic             oDone;

    modport master (
        output iCmdValid, iCmdOp, iCmdData, iCmdCount, iAbort, iQ,
        input  oCmdReady, oJ, oK, oBusy, oDone
    );

    modport slave (
        input  iCmdValid, iCmdOp, iCmdData, iCmdCount, iAbort, iQ,
        output oCmdReady, oJ, oK, oBusy, oDone
    );
endinterface

// File: rtl/jk_bank_sequencer.sv
// Turns load/clear/count/toggle commands into per-cycle J/K drive for an external
// bank of JK flip-flops that shares this clock; also clears the bank after reset.
module jk_bank_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                 iClk,
    input  logic                 iRstn,
    jk_bank_sequencer_if.slave   bus
);
    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_LOAD   = 3'd1;
    localparam logic [2:0] OP_CLEAR  = 3'd2;
    localparam logic [2:0] OP_UP     = 3'd3;
    localparam logic [2:0] OP_DOWN   = 3'd4;
    localparam logic [2:0] OP_TOGGLE = 3'd5;

    typedef enum logic [1:0] {
        S_INIT,
        S_IDLE,
        S_EXEC,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Ripple-style toggle enables: a bit flips when every lower bit is 1 (up) or 0 (down).
    logic [WIDTH-1:0] up_t;
    logic [WIDTH-1:0] dn_t;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_carry
            if (gi == 0) begin : g_lsb
                assign up_t[gi] = 1'b1;
                assign dn_t[gi] = 1'b1;
            end else begin : g_upper
                assign up_t[gi] = &bus.iQ[gi-1:0];
                assign dn_t[gi] = &(~bus.iQ[gi-1:0]);
            end
        end
    endgenerate

    logic is_counted_op;
    logic is_single_op;
    assign is_counted_op = (bus.iCmdOp == OP_UP) || (bus.iCmdOp == OP_DOWN) ||
                           (bus.iCmdOp == OP_TOGGLE);
    assign is_single_op  = (bus.iCmdOp == OP_LOAD) || (bus.iCmdOp == OP_CLEAR);

    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            state_q <= S_INIT;
            op_q    <= OP_NOP;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        data_d        = data_q;
        cnt_d         = cnt_q;
        bus.oJ        = '0;
        bus.oK        = '0;
        bus.oCmdReady = 1'b0;
        bus.oBusy     = 1'b0;
        bus.oDone     = 1'b0;

        case (state_q)
            S_INIT: begin
                bus.oK    = '1;
                bus.oBusy = 1'b1;
                state_d   = S_IDLE;
            end

            S_IDLE: begin
                bus.oCmdReady = 1'b1;
                if (bus.iCmdValid) begin
                    op_d   = bus.iCmdOp;
                    data_d = bus.iCmdData;
                    cnt_d  = is_single_op ? CNT_W'(1) : bus.iCmdCount;
                    // Nothing to execute: NOP, reserved opcodes and zero-length counts.
                    if (is_single_op || (is_counted_op && (bus.iCmdCount != '0))) begin
                        state_d = S_EXEC;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end

            S_EXEC: begin
                bus.oBusy = 1'b1;
                if (bus.iAbort) begin
                    state_d = S_DONE;
                end else begin
                    case (op_q)
                        OP_LOAD: begin
                            bus.oJ = data_q;
                            bus.oK = ~data_q;
                        end
                        OP_CLEAR: begin
                            bus.oK = '1;
                        end
                        OP_UP: begin
                            bus.oJ = up_t;
                            bus.oK = up_t;
                        end
                        OP_DOWN: begin
                            bus.oJ = dn_t;
                            bus.oK = dn_t;
                        end
                        OP_TOGGLE: begin
                            bus.oJ = data_q;
                            bus.oK = data_q;
                        end
                        default: begin
                            bus.oJ = '0;
                            bus.oK = '0;
                        end
                    endcase
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end

            S_DONE: begin
                bus.oDone = 1'b1;
                state_d   = S_IDLE;
            end

            default: begin
                state_d = S_INIT;
            end
        endcase
    end
endmodule
